// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer on the initiator side of the data cache port.
// Byte/halfword support is built only when MEMCTRL_SUBWORD_EN is defined.
//
// state | meaning
// IDLE  | ready, latches the next request
// READ  | cache read (load, or fetch for a sub-word store)
// WRITE | cache write
// RESP  | response held until resp_ready
module mem_access_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic         req_inst,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic [N-1:0] dataAddr,
    output logic [N-1:0] dataIn,
    output logic [1:0]   opType,
    output logic         inst_data,
    input  logic [N-1:0] dataOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } stateT;

    stateT        state;
    logic [N-1:0] addrQ;
    logic [N-1:0] dataInQ;
    logic [1:0]   sizeQ;
    logic         writeQ;
    logic         signedQ;
    logic         instQ;
    logic         reqErr;
    logic [N-1:0] loadWord;

    assign dataAddr  = {2'b00, addrQ[N-1:2]};
    assign dataIn    = dataInQ;
    assign inst_data = instQ;

`ifdef MEMCTRL_SUBWORD_EN
    logic [N-1:0] mergeWord;
    logic [7:0]   laneByte;
    logic [15:0]  laneHalf;

    // Lanes are little-endian within the 32-bit cache word.
    always_comb begin
        case (addrQ[1:0])
            2'b00:   laneByte = dataOut[7:0];
            2'b01:   laneByte = dataOut[15:8];
            2'b10:   laneByte = dataOut[23:16];
            default: laneByte = dataOut[31:24];
        endcase
        laneHalf = addrQ[1] ? dataOut[31:16] : dataOut[15:0];

        case (sizeQ)
            2'b00:   loadWord = {{(N-8){signedQ & laneByte[7]}}, laneByte};
            2'b01:   loadWord = {{(N-16){signedQ & laneHalf[15]}}, laneHalf};
            default: loadWord = dataOut;
        endcase

        mergeWord = dataOut;
        if (sizeQ == 2'b00) begin
            case (addrQ[1:0])
                2'b00:   mergeWord[7:0]   = dataInQ[7:0];
                2'b01:   mergeWord[15:8]  = dataInQ[7:0];
                2'b10:   mergeWord[23:16] = dataInQ[7:0];
                default: mergeWord[31:24] = dataInQ[7:0];
            endcase
        end else if (addrQ[1]) begin
            mergeWord[31:16] = dataInQ[15:0];
        end else begin
            mergeWord[15:0] = dataInQ[15:0];
        end
    end

    assign reqErr = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    logic unusedBits;

    assign loadWord   = dataOut;
    assign reqErr     = (req_size != 2'b10) || (req_addr[1:0] != 2'b00);
    assign unusedBits = ^{signedQ, sizeQ, writeQ, addrQ[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            opType     <= 2'b00;
            addrQ      <= '0;
            dataInQ    <= '0;
            sizeQ      <= 2'b00;
            writeQ     <= 1'b0;
            signedQ    <= 1'b0;
            instQ      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addrQ      <= req_addr;
                        dataInQ    <= req_wdata;
                        sizeQ      <= req_size;
                        writeQ     <= req_write;
                        signedQ    <= req_signed;
                        instQ      <= req_inst;
                        resp_rdata <= '0;
                        req_ready  <= 1'b0;
                        if (reqErr) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_write && req_size == 2'b10) begin
                            state  <= WRITE;
                            opType <= 2'b10;
                        end else begin
                            state  <= READ;
                            opType <= 2'b01;
                        end
                    end
                end
                READ: begin
`ifdef MEMCTRL_SUBWORD_EN
                    if (writeQ) begin
                        dataInQ <= mergeWord;
                        state   <= WRITE;
                        opType  <= 2'b10;
                    end else begin
                        resp_rdata <= loadWord;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                        opType     <= 2'b00;
                    end
`else
                    resp_rdata <= loadWord;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                    opType     <= 2'b00;
`endif
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                    opType     <= 2'b00;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of load/store vectors against a small cache model,
// plus backpressure and mid-operation reset sequences.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        req_inst;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dataAddr;
    logic [31:0] dataIn;
    logic [1:0]  opType;
    logic        inst_data;
    logic [31:0] dataOut;

    mem_access_ctrl #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_inst(req_inst),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dataAddr(dataAddr), .dataIn(dataIn), .opType(opType),
        .inst_data(inst_data), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    // Cache model: combinational read, write on the edge closing a WRITE cycle.
    logic [31:0] mem [64];
    logic        preload;
    assign dataOut = mem[dataAddr[5:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'h0;
            mem[8]  = 32'h80F0_0D7F;
            mem[12] = 32'h1122_3344;
            mem[16] = 32'hCAFE_F00D;
        end else if (opType == 2'b10) begin
            mem[dataAddr[5:0]] = dataIn;
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic        inst;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
        int          expRd;
        int          expWr;
    } vecT;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } expT;

    vecT         vecs [17];
    vecT         hv;
    expT         expQ [$];
    int          checks = 0;
    int          errors = 0;
    int          wrCnt;
    logic [31:0] lastWrData;
    logic [31:0] lastWrAddr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checkReset(input string nm);
        chk({nm, " req_ready"},  {31'b0, req_ready},  32'd1);
        chk({nm, " resp_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({nm, " resp_rdata"}, resp_rdata,          32'd0);
        chk({nm, " resp_err"},   {31'b0, resp_err},   32'd0);
        chk({nm, " opType"},     {30'b0, opType},     32'd0);
        chk({nm, " dataAddr"},   dataAddr,            32'd0);
        chk({nm, " dataIn"},     dataIn,              32'd0);
        chk({nm, " inst_data"},  {31'b0, inst_data},  32'd0);
    endtask

    // Drive one request, watch the cache port until the response, then hold it
    // for 'hold' cycles with resp_ready low before accepting it.
    task automatic runReq(input string nm, input vecT v, input int hold);
        expT e;
        expT got;
        int  cyc;
        int  nRd;
        int  nWr;
        e = '{v.expRdata, v.expErr, v.expLat, v.expRd, v.expWr};
`ifndef MEMCTRL_SUBWORD_EN
        if (v.sz != 2'b10) e = '{32'h0, 1'b1, 1, 0, 0};
`endif
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.sz;
        req_signed = v.sg;
        req_inst   = v.inst;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        resp_ready = (hold == 0);
        expQ.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        nRd = 0;
        nWr = 0;
        while (!resp_valid && cyc <= 6) begin
            if (opType == 2'b01) nRd++;
            if (opType == 2'b10) begin
                nWr++;
                lastWrData = dataIn;
                lastWrAddr = dataAddr;
            end
            chk({nm, " dataAddr"}, dataAddr, {2'b00, v.addr[31:2]});
            chk({nm, " inst_data"}, {31'b0, inst_data}, {31'b0, v.inst});
            @(posedge clk); #1;
            cyc++;
        end
        got = expQ.pop_front();
        if (!resp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: resp_valid low after %0d cycles, required by %0d", nm, cyc, got.lat);
        end else begin
            chk({nm, " latency"}, cyc, got.lat);
            chk({nm, " rdata"}, resp_rdata, got.rdata);
            chk({nm, " err"}, {31'b0, resp_err}, {31'b0, got.err});
            chk({nm, " reads"}, nRd, got.rd);
            chk({nm, " writes"}, nWr, got.wr);
            repeat (hold) begin
                @(negedge clk);
                req_valid = 1'b1;
                req_write = 1'b1;
                req_size  = 2'b10;
                req_addr  = v.addr;
                req_wdata = 32'h0BAD_F00D;
                @(posedge clk); #1;
                chk({nm, " held valid"}, {31'b0, resp_valid}, 32'd1);
                chk({nm, " held rdata"}, resp_rdata, got.rdata);
                chk({nm, " held req_ready"}, {31'b0, req_ready}, 32'd0);
                chk({nm, " held opType"}, {30'b0, opType}, 32'd0);
            end
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, " req_ready after"}, {31'b0, req_ready}, 32'd1);
        chk({nm, " resp_valid after"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // wr, sz, sg, inst, addr, wdata, expRdata, expErr, expLat, expRd, expWr
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 1'b1, 32'h30, 32'h0,         32'h1122_3344, 1'b0, 2, 1, 0};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h23, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 1, 0};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h23, 32'h0,         32'h0000_0080, 1'b0, 2, 1, 0};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h20, 32'h0,         32'h0000_007F, 1'b0, 2, 1, 0};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 1'b0, 32'h22, 32'h0,         32'hFFFF_80F0, 1'b0, 2, 1, 0};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h20, 32'h0,         32'h0000_0D7F, 1'b0, 2, 1, 0};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h22, 32'h0,         32'hFFFF_FFF0, 1'b0, 2, 1, 0};
        vecs[9]  = '{1'b0, 2'b10, 1'b1, 1'b0, 32'h20, 32'h0,         32'h80F0_0D7F, 1'b0, 2, 1, 0};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h06, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[11] = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h21, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h20, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h33, 32'h1234,      32'h0,         1'b1, 1, 0, 0};
        vecs[14] = '{1'b1, 2'b00, 1'b0, 1'b1, 32'h41, 32'h1234_5655, 32'h0,         1'b0, 3, 1, 1};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h41, 32'h0,         32'h0000_0055, 1'b0, 2, 1, 0};
        vecs[16] = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h40, 32'h0,         32'h0000_550D, 1'b0, 2, 1, 0};

        rst        = 1'b1;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_inst   = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        lastWrData = 32'h0;
        lastWrAddr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        @(negedge clk);
        rst     = 1'b0;
        preload = 1'b0;

        for (int i = 0; i < 17; i++) begin
            runReq($sformatf("vec%0d", i), vecs[i], 0);
            if (i == 0) begin
                chk("store dataIn", lastWrData, 32'hDEAD_BEEF);
                chk("store dataAddr", lastWrAddr, 32'h4);
            end
        end

`ifdef MEMCTRL_SUBWORD_EN
        hv = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h32, 32'hAAAA_BEEF, 32'h0, 1'b0, 3, 1, 1};
        runReq("rmw_half", hv, 0);
        chk("rmw dataIn", lastWrData, 32'hBEEF_3344);
        chk("rmw dataAddr", lastWrAddr, 32'hC);
        hv = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h30, 32'h0, 32'hBEEF_3344, 1'b0, 2, 1, 0};
        runReq("rmw_readback", hv, 0);
`else
        hv = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h30, 32'h55, 32'h0, 1'b1, 1, 0, 0};
        runReq("byte_store_disabled", hv, 0);
        hv = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h30, 32'h0, 32'h1122_3344, 1'b0, 2, 1, 0};
        runReq("disabled_readback", hv, 0);
`endif

        hv = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0};
        runReq("backpressure", hv, 5);
        runReq("after_backpressure", hv, 0);

        // Reset while a byte store is in its READ cycle: no write may follow.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_inst   = 1'b1;
        req_addr   = 32'h40;
        req_wdata  = 32'h99;
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef MEMCTRL_SUBWORD_EN
        chk("rst_mid read issued", {30'b0, opType}, 32'd1);
`else
        chk("rst_mid err", {31'b0, resp_err}, 32'd1);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkReset("rst_mid");
        @(negedge clk);
        rst   = 1'b0;
        wrCnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (opType == 2'b10) wrCnt++;
        end
        chk("rst_mid writes", wrCnt, 0);
`ifdef MEMCTRL_SUBWORD_EN
        chk("rst_mid mem", mem[16], 32'hCAFE_550D);
        hv = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h40, 32'h0, 32'hCAFE_550D, 1'b0, 2, 1, 0};
`else
        chk("rst_mid mem", mem[16], 32'hCAFE_F00D);
        hv = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1, 0};
`endif
        runReq("after_rst_mid", hv, 0);

        chk("scoreboard drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
